// File: rtl/uart_alu_responder.sv
// UART ALU packet engine: parses opcode/LEN header, then echoes, sums or multiplies 32-bit LE operands.
// Result streams LSB first 2 cycles after the last payload byte; echo mode ties RX ready to TX ready.
module uart_alu_responder #(
  parameter int         DATA_WIDTH  = 8,
  parameter logic [7:0] OPCODE_ECHO = 8'hEC,
  parameter logic [7:0] OPCODE_ADD  = 8'hA0,
  parameter logic [7:0] OPCODE_MUL  = 8'h88
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [3:0] {
    IDLE, HDR1, HDR2, HDR3, DISPATCH, ECHO, OPERAND, RESULT, DRAIN
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            opcode;
  logic [15:0]           len;
  logic [15:0]           rem;
  logic [31:0]           acc;
  logic [31:0]           opnd;
  logic [1:0]            cnt;
  logic                  pend;

  logic                  s_rdy, m_vld, err;
  logic [DATA_WIDTH-1:0] m_dat;
  logic                  is_add, is_mul, is_echo, len_short, disp_err;
  logic [15:0]           len_rem;
  logic                  s_fire, m_fire;

  always_comb begin
    state_nxt = state;
    s_rdy     = 1'b0;
    m_vld     = 1'b0;
    m_dat     = '0;
    err       = 1'b0;
    is_add    = (opcode == OPCODE_ADD);
    is_mul    = (opcode == OPCODE_MUL);
    is_echo   = (opcode == OPCODE_ECHO);
    len_short = (len < 16'd4);
    len_rem   = len - 16'd4;
    disp_err  = !(is_add || is_mul || is_echo) || len_short ||
                ((is_add || is_mul) && (len_rem[1:0] != 2'b00));
    case (state)
      IDLE: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) state_nxt = HDR1;
      end
      HDR1: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) state_nxt = HDR2;
      end
      HDR2: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) state_nxt = HDR3;
      end
      HDR3: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) state_nxt = DISPATCH;
      end
      DISPATCH: begin
        if (disp_err) begin
          err       = 1'b1;
          state_nxt = (len_short || len_rem == 16'd0) ? IDLE : DRAIN;
        end else if (len_rem == 16'd0) begin
          state_nxt = is_echo ? IDLE : RESULT;
        end else begin
          state_nxt = is_echo ? ECHO : OPERAND;
        end
      end
      ECHO: begin
        m_dat = s_axis_tdata;
        m_vld = s_axis_tvalid;
        s_rdy = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && rem == 16'd1) state_nxt = IDLE;
      end
      OPERAND: begin
        // rem==0 here is the accumulate cycle after the final byte; hold off the next packet
        s_rdy = (rem != 16'd0);
        if (rem == 16'd0) state_nxt = RESULT;
      end
      RESULT: begin
        m_vld = 1'b1;
        m_dat = acc[{cnt, 3'b000} +: 8];
        if (m_axis_tready && cnt == 2'd3) state_nxt = IDLE;
      end
      DRAIN: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid && rem == 16'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_fire = s_axis_tvalid && s_rdy;
  assign m_fire = m_vld && m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      opcode <= '0;
      len    <= '0;
      rem    <= '0;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
    end else begin
      pend <= 1'b0;
      // operand completed on the previous edge; fold it in now
      if (pend) acc <= is_mul ? acc * opnd : acc + opnd;
      case (state)
        IDLE:     if (s_fire) opcode <= s_axis_tdata;
        HDR2:     if (s_fire) len[7:0] <= s_axis_tdata;
        HDR3:     if (s_fire) len[15:8] <= s_axis_tdata;
        DISPATCH: begin
          rem <= len_short ? 16'd0 : len_rem;
          acc <= is_mul ? 32'd1 : 32'd0;
          cnt <= 2'd0;
        end
        ECHO:     if (s_fire) rem <= rem - 16'd1;
        OPERAND: begin
          if (s_fire) begin
            opnd <= {s_axis_tdata, opnd[31:8]};
            cnt  <= cnt + 2'd1;
            rem  <= rem - 16'd1;
            if (cnt == 2'd3) pend <= 1'b1;
          end
        end
        RESULT:   if (m_fire) cnt <= cnt + 2'd1;
        DRAIN:    if (s_fire) rem <= rem - 16'd1;
        default: ;
      endcase
    end
  end

  assign s_axis_tready = rst && s_rdy;
  assign m_axis_tvalid = rst && m_vld;
  assign m_axis_tdata  = rst ? m_dat : '0;
  assign busy_o        = rst && (state != IDLE);
  assign err_o         = rst && err;

endmodule

// File: tb/tb_uart_alu_responder.sv
// Bench for uart_alu_responder: directed and random packets scored against a packet-level model.
module tb_uart_alu_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy_o;
  logic       err_o;

  uart_alu_responder dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] pkt[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       exp_err;
  int         err_cnt = 0;
  int         cyc = 0;
  int         last_s_cyc = 0;
  int         first_m_cyc = -1;
  int         rdy_mode = 0;
  logic       echo_watch = 1'b0;
  int         mirror_seen = 0;
  int         mirror_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Packet-level reference: interpret header and payload with plain arithmetic
  function automatic void model();
    logic [7:0]  op;
    logic [15:0] len;
    int          nrem;
    logic [31:0] a, w;
    op   = pkt[0];
    len  = {pkt[3], pkt[2]};
    exp_q.delete();
    exp_err = 1'b0;
    nrem = int'(len) - 4;
    if (nrem < 0 || !(op == 8'hEC || op == 8'hA0 || op == 8'h88) ||
        (op != 8'hEC && nrem % 4 != 0)) begin
      exp_err = 1'b1;
      return;
    end
    if (op == 8'hEC) begin
      for (int i = 0; i < nrem; i++) exp_q.push_back(pkt[4+i]);
    end else begin
      a = (op == 8'h88) ? 32'd1 : 32'd0;
      for (int k = 0; k < nrem / 4; k++) begin
        w = {pkt[7+4*k], pkt[6+4*k], pkt[5+4*k], pkt[4+4*k]};
        a = (op == 8'hA0) ? a + w : a * w;
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(a[8*i +: 8]);
    end
  endfunction

  function automatic void hdr(input logic [7:0] op, input logic [15:0] len);
    pkt.delete();
    pkt.push_back(op);
    pkt.push_back(8'($urandom));
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
  endfunction

  function automatic void word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) pkt.push_back(w[8*i +: 8]);
  endfunction

  // Monitor: all sampling on the falling edge, inputs change just after the rising edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (s_axis_tvalid && s_axis_tready) last_s_cyc = cyc;
      if (m_axis_tvalid && first_m_cyc < 0) first_m_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
      if (err_o) err_cnt++;
      if (echo_watch && m_axis_tvalid) begin
        mirror_seen++;
        if (s_axis_tready !== m_axis_tready) mirror_bad++;
      end
    end
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called and returns just after a rising edge
  task automatic send_pkt();
    logic ok;
    int   guard;
    for (int i = 0; i < pkt.size(); i++) begin
      s_axis_tdata  = pkt[i];
      s_axis_tvalid = 1'b1;
      guard = 0;
      ok = 1'b0;
      while (!ok && guard < 200) begin
        @(negedge clk);
        ok = s_axis_tready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!ok) begin
        check("send_timeout", 32'(ok), 32'd1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
  endtask

  task automatic run_pkt(input string tag);
    int guard;
    logic [7:0] op;
    model();
    op = pkt[0];
    rx_q.delete();
    err_cnt = 0;
    first_m_cyc = -1;
    send_pkt();
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy_o && guard < 300);
    if (busy_o) check({tag, "_idle_timeout"}, 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    if (!exp_err && op != 8'hEC && pkt.size() > 4)
      check({tag, "_lat"}, 32'(first_m_cyc - last_s_cyc), 32'd2);
  endtask

  initial begin
    int kind, nw, len;
    logic [7:0] op;
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_s_rdy", 32'(s_axis_tready), 32'd0);
    check("rst_m_vld", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_dat", 32'(m_axis_tdata), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_s_rdy", 32'(s_axis_tready), 32'd1);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;

    hdr(8'hA0, 16'h000C); word(32'h1); word(32'h2);
    run_pkt("add_1_2");
    hdr(8'hA0, 16'h000C); word(32'hFFFF_FFFF); word(32'h1);
    run_pkt("add_wrap");
    hdr(8'h88, 16'h0010); word(32'h0001_0000); word(32'h0001_0000); word(32'h3);
    run_pkt("mul_ovf");
    hdr(8'h88, 16'h000C); word(32'h7); word(32'h6);
    run_pkt("mul_42");

    rdy_mode = 1;
    echo_watch = 1'b1;
    mirror_seen = 0;
    mirror_bad = 0;
    hdr(8'hEC, 16'h0007); pkt.push_back(8'h41); pkt.push_back(8'h42); pkt.push_back(8'h43);
    run_pkt("echo_abc");
    echo_watch = 1'b0;
    check("echo_mirror_bad", 32'(mirror_bad), 32'd0);
    check("echo_mirror_seen", 32'(mirror_seen > 0), 32'd1);
    rdy_mode = 0;

    hdr(8'h55, 16'h0006); pkt.push_back(8'h11); pkt.push_back(8'h22);
    run_pkt("bad_op");
    hdr(8'hA0, 16'h0008); word(32'h1234_5678);
    run_pkt("add_after_badop");
    hdr(8'hA0, 16'h0007); pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03);
    run_pkt("add_len7");
    hdr(8'hA0, 16'h000C); word(32'h10); word(32'h20);
    run_pkt("add_after_len7");
    hdr(8'hA0, 16'h0002);
    run_pkt("len_short");
    hdr(8'h88, 16'h0004);
    run_pkt("mul_empty");
    hdr(8'hEC, 16'h0004);
    run_pkt("echo_empty");

    // Abandon a packet mid-operand with reset
    hdr(8'hA0, 16'h000C); pkt.push_back(8'h01); pkt.push_back(8'h00);
    rx_q.delete();
    err_cnt = 0;
    send_pkt();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_s_rdy", 32'(s_axis_tready), 32'd0);
      check("midrst_m_vld", 32'(m_axis_tvalid), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_out", 32'(rx_q.size()), 32'd0);
    check("midrst_no_err", 32'(err_cnt), 32'd0);
    hdr(8'hA0, 16'h000C); word(32'hDEAD_0000); word(32'h0000_BEEF);
    run_pkt("add_after_rst");

    for (int n = 0; n < 40; n++) begin
      rdy_mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: begin
          nw = $urandom_range(0, 4);
          hdr(kind == 0 ? 8'hA0 : 8'h88, 16'(4 + 4 * nw));
          for (int k = 0; k < nw; k++) word($urandom);
        end
        2: begin
          len = $urandom_range(4, 12);
          hdr(8'hEC, 16'(len));
          for (int k = 4; k < len; k++) pkt.push_back(8'($urandom));
        end
        3: begin
          do op = 8'($urandom); while (op == 8'hEC || op == 8'hA0 || op == 8'h88);
          len = $urandom_range(4, 9);
          hdr(op, 16'(len));
          for (int k = 4; k < len; k++) pkt.push_back(8'($urandom));
        end
        4: begin
          len = 4 + 4 * $urandom_range(0, 2) + $urandom_range(1, 3);
          hdr($urandom_range(0, 1) ? 8'hA0 : 8'h88, 16'(len));
          for (int k = 4; k < len; k++) pkt.push_back(8'($urandom));
        end
        default: hdr($urandom_range(0, 1) ? 8'hEC : 8'hA0, 16'($urandom_range(0, 3)));
      endcase
      run_pkt($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_alu_responder.md
Name: uart_alu_responder

Overview:
- Device-side packet engine for the UART ALU; sits between the UART RX and TX AXI-stream ports inside top.
- Parses host command packets byte by byte from the UART receiver.
- Executes echo, 32-bit add, or 32-bit multiply.
- Streams the response bytes to the UART transmitter.
- It is the responder to the host-side sender driving the UART link.

Parameters:
- DATA_WIDTH, 8, stream byte width; only 8 is supported.
- OPCODE_ECHO, 8'hEC, echo opcode.
- OPCODE_ADD, 8'hA0, 32-bit add opcode.
- OPCODE_MUL, 8'h88, 32-bit multiply opcode.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset; 0 resets on a rising clk edge.
- s_axis_tdata  input  DATA_WIDTH  byte from the UART receiver.
- s_axis_tvalid  input  1  receive byte valid.
- s_axis_tready  output  1  block accepts the byte.
- m_axis_tdata  output  DATA_WIDTH  byte to the UART transmitter.
- m_axis_tvalid  output  1  transmit byte valid.
- m_axis_tready  input  1  transmitter accepts the byte.
- busy_o  output  1  high whenever state is not IDLE.
- err_o  output  1  one-cycle pulse on a rejected packet.

Behaviour:
- Transfer rule: a byte moves on a rising clk edge with tvalid && tready.
- m_axis_tvalid, once high, holds m_axis_tdata stable until accepted.
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8], then LEN-4 payload bytes.
- LEN is the total packet length including the 4-byte header.
- Reset (rst=0), every output: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, busy_o=0, err_o=0.
- Reset also sets state=IDLE and clears the accumulator, operand shift register and counter.
- Reset mid-packet abandons the packet; no partial response is sent.
- States: IDLE, HDR1, HDR2, HDR3, DISPATCH, ECHO, OPERAND, RESULT, DRAIN.
- IDLE: s_axis_tready=1. Accepted byte is latched as opcode -> HDR1.
- HDR1/HDR2/HDR3: s_axis_tready=1; each accepted byte advances the state. HDR2 latches LEN low, HDR3 latches LEN high -> DISPATCH.
- DISPATCH (1 cycle, s_axis_tready=0): rem=LEN-4; acc=0 for ADD, 1 for MUL. Error if any of:
  - opcode unknown;
  - LEN<4;
  - ADD/MUL with rem[1:0]!=0.
- DISPATCH routing:
  - Error: err_o=1 this cycle; go to DRAIN, or to IDLE if LEN<4 or rem==0.
  - ECHO with rem==0: -> IDLE, no output.
  - ADD/MUL with rem==0: -> RESULT.
  - Otherwise: -> ECHO or OPERAND.
- ECHO: combinational pass-through.
  - m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - rem decrements per transfer; -> IDLE on the transfer that makes rem 0.
- OPERAND: s_axis_tready=1. Bytes shift in little-endian.
  - On the 4th byte of an operand, the next-edge update is ADD acc<=acc+op mod 2^32, MUL acc<=(acc*op)[31:0]. Upper product bits are discarded.
  - After the last payload byte -> RESULT.
- RESULT: s_axis_tready=0. Sends acc as 4 bytes, LSB first. m_axis_tvalid=1 from the first RESULT cycle.
  - Response latency: the first result byte is valid 2 cycles after the last payload byte is accepted.
  - Accepting the 4th byte -> IDLE; m_axis_tvalid=0 the next cycle.
- DRAIN: s_axis_tready=1; discards rem bytes; -> IDLE when rem reaches 0. No output.
- m_axis_tvalid=0 in all states except RESULT and ECHO.
- Back-to-back packets: IDLE accepts the next opcode the cycle after return. No bytes are lost, because the receiver holds tvalid.
- LEN=16'hFFFF is legal for ECHO/DRAIN. rem is a 16-bit down-counter and never wraps below 0.

Test Plan:
- Reset held low 5 cycles, then released -> all outputs 0, busy_o=0. s_axis_tready=1 the cycle after release.
- ADD packet A0 00 0C 00 | 01 00 00 00 | 02 00 00 00 -> response bytes 03 00 00 00, then IDLE.
- ADD FF FF FF FF + 01 00 00 00 (LEN=0x0C) -> 00 00 00 00, wrap-around.
- MUL 88 00 10 00 with operands 0x00010000, 0x00010000, 0x00000003 -> 00 00 00 00. Then MUL with 0x00000007 and 0x00000006 (LEN=0x0C) -> 2A 00 00 00.
- ECHO EC 00 07 00 | 41 42 43, with m_axis_tready toggling 1/0 -> 41 42 43 in order, none dropped or duplicated. s_axis_tready mirrors m_axis_tready.
- Error cases, each followed by a valid ADD packet that must produce its correct result:
  - opcode 0x55 with LEN=6 -> err_o pulse, 2 bytes drained, no output.
  - ADD with LEN=7 -> err_o pulse, 3 bytes drained.
  - rst asserted after 2 operand bytes -> no output.
